axil_adaptor_mo: RTL and testbench



---
 rtl/axil_adaptor_mo_if.sv | 59 +++++
 rtl/axil_adaptor_mo.sv | 143 ++++++++++++++
 tb/tb_axil_adaptor_mo.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_adaptor_mo_if.sv
// Core-side request/response and AXI4-lite master signal bundle for axil_adaptor_mo.
// The master modport is the adaptor's view; the slave modport is the environment's view.
interface axil_adaptor_mo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TAG_WIDTH  = 32
);
    logic                  intf_req_val;
    logic                  intf_req_ready;
    logic [ADDR_WIDTH-1:0] intf_addr;
    logic [DATA_WIDTH-1:0] intf_wdata;
    logic                  intf_ren;
    logic [STRB_WIDTH-1:0] intf_wen;
    logic [TAG_WIDTH-1:0]  intf_req_tag;
    logic                  intf_rsp_val;
    logic                  intf_rsp_ready;
    logic                  intf_rsp_error;
    logic [DATA_WIDTH-1:0] intf_rdata;
    logic [TAG_WIDTH-1:0]  intf_rsp_tag;

    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [DATA_WIDTH-1:0] axi_wdata;
    logic [STRB_WIDTH-1:0] axi_wstrb;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [1:0]            axi_bresp;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rvalid;
    logic                  axi_rready;

    modport master (
        input  intf_req_val, intf_addr, intf_wdata, intf_ren, intf_wen, intf_req_tag,
        input  intf_rsp_ready,
        output intf_req_ready, intf_rsp_val, intf_rsp_error, intf_rdata, intf_rsp_tag,
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_araddr, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport slave (
        output intf_req_val, intf_addr, intf_wdata, intf_ren, intf_wen, intf_req_tag,
        output intf_rsp_ready,
        input  intf_req_ready, intf_rsp_val, intf_rsp_error, intf_rdata, intf_rsp_tag,
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_araddr, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );
endinterface

// File: rtl/axil_adaptor_mo.sv
// AXI4-lite master adaptor: one issue register plus an in-order response FIFO.
// Define AXIL_ADAPTOR_ERRLOG_EN to add the sticky first-error address log.
module axil_adaptor_mo #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned TAG_WIDTH   = 32,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef AXIL_ADAPTOR_ERRLOG_EN
    input  logic                  err_clr,
    output logic                  err_sticky,
    output logic [ADDR_WIDTH-1:0] err_addr,
`endif
    axil_adaptor_mo_if.master     bus
);
    localparam int unsigned PTR_W = $clog2(OUTSTANDING);

    logic                  busy_q, is_wr_q, aw_done_q, w_done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wen_q;

    logic                  ord_wr_q  [OUTSTANDING];
    logic [TAG_WIDTH-1:0]  ord_tag_q [OUTSTANDING];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [PTR_W:0]        count_q;

    logic ord_full, head_val, head_wr;
    logic req_is_wr, req_is_rd, accept, push, pop;
    logic aw_hs, w_hs, ar_hs, issue_done;

    // Bus valids are pure functions of registered state.
    assign bus.axi_awvalid = busy_q & is_wr_q & ~aw_done_q;
    assign bus.axi_wvalid  = busy_q & is_wr_q & ~w_done_q;
    assign bus.axi_arvalid = busy_q & ~is_wr_q;
    assign bus.axi_awaddr  = addr_q;
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_wdata   = wdata_q;
    assign bus.axi_wstrb   = wen_q;

    assign aw_hs      = bus.axi_awvalid & bus.axi_awready;
    assign w_hs       = bus.axi_wvalid & bus.axi_wready;
    assign ar_hs      = bus.axi_arvalid & bus.axi_arready;
    assign issue_done = busy_q & (is_wr_q ? ((aw_done_q | aw_hs) & (w_done_q | w_hs)) : ar_hs);

    // Full is judged before any same-cycle pop, so a full FIFO never takes a push.
    assign ord_full           = (count_q == (PTR_W + 1)'(OUTSTANDING));
    assign bus.intf_req_ready = (~busy_q | issue_done) & ~ord_full;
    assign accept             = bus.intf_req_val & bus.intf_req_ready;
    assign req_is_wr          = |bus.intf_wen;
    assign req_is_rd          = bus.intf_ren & ~req_is_wr;
    assign push               = accept & (req_is_wr | req_is_rd);

    assign head_val           = (count_q != '0);
    assign head_wr            = ord_wr_q[rptr_q];
    assign bus.axi_bready     = head_val & head_wr & bus.intf_rsp_ready;
    assign bus.axi_rready     = head_val & ~head_wr & bus.intf_rsp_ready;
    assign bus.intf_rsp_val   = head_val & (head_wr ? bus.axi_bvalid : bus.axi_rvalid);
    assign bus.intf_rsp_error = head_wr ? bus.axi_bresp[1] : bus.axi_rresp[1];
    assign bus.intf_rsp_tag   = ord_tag_q[rptr_q];
    assign bus.intf_rdata     = bus.axi_rdata;
    assign pop                = bus.intf_rsp_val & bus.intf_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            is_wr_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= '0;
        end else if (accept) begin
            // A request with neither read nor write set leaves the issue slot idle.
            busy_q    <= push;
            is_wr_q   <= req_is_wr;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= bus.intf_addr;
            wdata_q   <= bus.intf_wdata;
            wen_q     <= bus.intf_wen;
        end else if (issue_done) begin
            busy_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ord_wr_q[wptr_q]  <= req_is_wr;
            ord_tag_q[wptr_q] <= bus.intf_req_tag;
        end
    end

`ifdef AXIL_ADAPTOR_ERRLOG_EN
    logic [ADDR_WIDTH-1:0] ord_addr_q [OUTSTANDING];
    logic                  err_sticky_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    always_ff @(posedge clk) begin
        if (push) ord_addr_q[wptr_q] <= bus.intf_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else if (err_clr) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else if (pop & bus.intf_rsp_error & ~err_sticky_q) begin
            err_sticky_q <= 1'b1;
            err_addr_q   <= ord_addr_q[rptr_q];
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_addr   = err_addr_q;
`endif
endmodule

// File: tb/tb_axil_adaptor_mo.sv
// Self-checking bench for axil_adaptor_mo: vector table, directed corner sequences and a
// randomized run scored against an in-order transaction model.
module tb_axil_adaptor_mo;
    localparam int unsigned DW = 32, AW = 32, SW = 4, TW = 32, OUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    axil_adaptor_mo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TAG_WIDTH(TW)) bus ();

`ifdef AXIL_ADAPTOR_ERRLOG_EN
    logic          err_clr = 1'b0;
    logic          err_sticky;
    logic [AW-1:0] err_addr;
`endif

    axil_adaptor_mo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TAG_WIDTH(TW), .OUTSTANDING(OUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef AXIL_ADAPTOR_ERRLOG_EN
        .err_clr   (err_clr),
        .err_sticky(err_sticky),
        .err_addr  (err_addr),
`endif
        .bus       (bus)
    );

    typedef struct {
        logic          ren;
        logic [SW-1:0] wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [TW-1:0] tag;
        int            lat;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
        logic          exp_rsp;
        logic          exp_wr;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic          wr;
        logic [TW-1:0] tag;
        logic [DW-1:0] rdata;
        logic          err;
        logic [AW-1:0] addr;
    } rsp_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.intf_req_val = 0; bus.intf_addr = '0; bus.intf_wdata = '0; bus.intf_ren = 0;
        bus.intf_wen = '0; bus.intf_req_tag = '0; bus.intf_rsp_ready = 0;
        bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_bresp = 2'b00; bus.axi_bvalid = 0;
        bus.axi_arready = 0; bus.axi_rdata = '0; bus.axi_rresp = 2'b00; bus.axi_rvalid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();
    endtask

    task automatic drive_req(input logic ren, input logic [SW-1:0] wen, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [TW-1:0] tag);
        bus.intf_req_val = 1; bus.intf_ren = ren; bus.intf_wen = wen;
        bus.intf_addr = addr; bus.intf_wdata = wdata; bus.intf_req_tag = tag;
    endtask

    task automatic run_vec(input vec_t v);
        bus.axi_arready = 1; bus.axi_awready = 1; bus.axi_wready = 1; bus.intf_rsp_ready = 1;
        drive_req(v.ren, v.wen, v.addr, v.wdata, v.tag);
        #1 chk("vec_req_ready", bus.intf_req_ready, 1);
        tick();
        bus.intf_req_val = 0; bus.intf_ren = 0; bus.intf_wen = '0;
        #1;
        chk("vec_arvalid", bus.axi_arvalid, v.exp_rsp & ~v.exp_wr);
        chk("vec_awvalid", bus.axi_awvalid, v.exp_rsp & v.exp_wr);
        chk("vec_ready_after", bus.intf_req_ready, 1);
        if (v.exp_rsp && v.exp_wr) begin
            chk("vec_awaddr", bus.axi_awaddr, v.addr);
            chk("vec_wdata", {bus.axi_wdata, bus.axi_wstrb}, {v.wdata, v.wen});
        end else if (v.exp_rsp) begin
            chk("vec_araddr", bus.axi_araddr, v.addr);
        end
        tick();
        repeat (v.lat) tick();
        if (v.exp_wr) begin
            bus.axi_bvalid = 1; bus.axi_bresp = v.resp;
        end else begin
            bus.axi_rvalid = 1; bus.axi_rresp = v.resp; bus.axi_rdata = v.rdata;
        end
        #1 chk("vec_rsp_val", bus.intf_rsp_val, v.exp_rsp);
        if (v.exp_rsp) begin
            chk("vec_rsp_tag", bus.intf_rsp_tag, v.tag);
            chk("vec_rsp_error", bus.intf_rsp_error, v.exp_err);
            if (!v.exp_wr) chk("vec_rdata", bus.intf_rdata, v.rdata);
        end
        tick();
        #1 chk("vec_popped_once", bus.intf_rsp_val, 0);
        bus.axi_bvalid = 0; bus.axi_rvalid = 0;
        tick();
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Random-phase model state.
    rsp_t          exp_rsp_q[$];
    logic [AW-1:0] exp_aw_q[$], exp_ar_q[$];
    logic [DW+SW-1:0] exp_w_q[$];
    logic [AW-1:0] slv_rd_q[$], slv_aw_q[$], slv_b_q[$];
    int            slv_w_cnt;
    logic          m_sticky;
    logic [AW-1:0] m_addr;

    initial begin
        vecs[0] = '{1'b1, 4'h0, 32'h100, 32'h0,        32'h5, 2, 2'b00, 32'hDEADBEEF, 1, 0, 0};
        vecs[1] = '{1'b0, 4'hF, 32'h200, 32'h11223344, 32'h6, 1, 2'b00, 32'h0,        1, 1, 0};
        vecs[2] = '{1'b1, 4'h0, 32'h104, 32'h0,        32'h7, 0, 2'b10, 32'h0BADF00D, 1, 0, 1};
        vecs[3] = '{1'b0, 4'h1, 32'h208, 32'hA5A5A5A5, 32'h8, 3, 2'b11, 32'h0,        1, 1, 1};
        vecs[4] = '{1'b1, 4'h3, 32'h20C, 32'h55AA55AA, 32'h9, 0, 2'b00, 32'h0,        1, 1, 0};
        vecs[5] = '{1'b0, 4'h0, 32'h210, 32'h0,        32'hA, 0, 2'b00, 32'h0,        0, 0, 0};
        vecs[6] = '{1'b1, 4'h0, 32'h108, 32'h0,        32'hB, 1, 2'b01, 32'h13579BDF, 1, 0, 0};
        vecs[7] = '{1'b0, 4'hC, 32'h20C, 32'hFFFF0000, 32'hFFFFFFFF, 0, 2'b10, 32'h0, 1, 1, 1};

        // Reset state.
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valids", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid}, 0);
        chk("rst_readies", {bus.axi_bready, bus.axi_rready, bus.intf_rsp_val}, 0);
        rst_n = 1;
        tick();
        chk("rst_req_ready", bus.intf_req_ready, 1);
`ifdef AXIL_ADAPTOR_ERRLOG_EN
        chk("rst_err", {err_sticky, err_addr}, 0);
`endif

        foreach (vecs[i]) run_vec(vecs[i]);

        // Write whose AW stalls three cycles after W completes.
        bus.axi_awready = 0; bus.axi_wready = 1; bus.intf_rsp_ready = 1;
        drive_req(1'b0, 4'hF, 32'h200, 32'hCAFEF00D, 32'h7);
        tick();
        bus.intf_req_val = 0;
        #1 chk("aw_wait_both", {bus.axi_awvalid, bus.axi_wvalid}, 2'b11);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("aw_alone", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_awaddr}, {2'b10, 32'h200});
            chk("aw_busy", bus.intf_req_ready, 0);
            tick();
        end
        bus.axi_awready = 1;
        #1 chk("aw_done_ready", bus.intf_req_ready, 1);
        tick();
        chk("aw_dropped", bus.axi_awvalid, 0);
        bus.axi_bvalid = 1; bus.axi_bresp = 2'b00;
        #1 chk("aw_rsp", {bus.intf_rsp_val, bus.intf_rsp_error, bus.intf_rsp_tag}, {2'b10, 32'h7});
        tick();
        bus.axi_bvalid = 0;

        // Fill the order FIFO with reads; the fifth request waits for a pop.
        bus.axi_arready = 1; bus.intf_rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 4'h0, 32'h400 + 32'(i * 4), 32'h0, 32'(10 + i));
            #1 chk("fill_ready", bus.intf_req_ready, 1);
            tick();
        end
        drive_req(1'b1, 4'h0, 32'h410, 32'h0, 32'd14);
        for (int i = 0; i < 3; i++) begin
            #1 chk("full_blocks", bus.intf_req_ready, 0);
            tick();
        end
        bus.axi_rvalid = 1; bus.axi_rdata = 32'h1;
        #1;
        chk("full_pop_rsp", {bus.intf_rsp_val, bus.intf_rsp_tag}, {1'b1, 32'd10});
        chk("full_pop_noready", bus.intf_req_ready, 0);
        tick();
        bus.axi_rvalid = 0;
        #1 chk("full_after_pop", bus.intf_req_ready, 1);
        tick();
        bus.intf_req_val = 0;
        for (int i = 1; i < 5; i++) begin
            bus.axi_rvalid = 1;
            #1 chk("drain_order", {bus.intf_rsp_val, bus.intf_rsp_tag}, {1'b1, 32'(10 + i)});
            tick();
        end
        bus.axi_rvalid = 0;
        #1 chk("drain_empty", bus.axi_rready, 0);
        tick();

        // Write then read; R arrives first and must wait behind B.
        bus.axi_awready = 1; bus.axi_wready = 1; bus.axi_arready = 1; bus.intf_rsp_ready = 1;
        drive_req(1'b0, 4'hF, 32'h40, 32'h0, 32'd1);
        tick();
        drive_req(1'b1, 4'h0, 32'h44, 32'h0, 32'd2);
        #1 chk("ilv_b2b_ready", bus.intf_req_ready, 1);
        tick();
        bus.intf_req_val = 0;
        tick();
        bus.axi_rvalid = 1; bus.axi_rdata = 32'h1234;
        #1 chk("ilv_r_stall", {bus.axi_rready, bus.axi_bready, bus.intf_rsp_val}, 3'b010);
        tick();
        bus.axi_bvalid = 1; bus.axi_bresp = 2'b00;
        #1 chk("ilv_first", {bus.intf_rsp_val, bus.axi_rready, bus.intf_rsp_tag}, {2'b10, 32'd1});
        tick();
        bus.axi_bvalid = 0;
        #1 chk("ilv_second", {bus.intf_rsp_val, bus.axi_rready, bus.intf_rsp_tag, bus.intf_rdata},
               {2'b11, 32'd2, 32'h1234});
        tick();
        bus.axi_rvalid = 0;

        // Consumer back-pressure holds the response without popping.
        drive_req(1'b1, 4'h0, 32'h80, 32'h0, 32'h33);
        tick();
        bus.intf_req_val = 0;
        tick();
        bus.axi_rvalid = 1; bus.axi_rdata = 32'hCAFE; bus.intf_rsp_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("bp_hold", {bus.axi_rready, bus.intf_rsp_val, bus.intf_rsp_tag},
                   {2'b01, 32'h33});
            tick();
        end
        bus.intf_rsp_ready = 1;
        #1 chk("bp_release", bus.axi_rready, 1);
        tick();
        chk("bp_single_pop", bus.intf_rsp_val, 0);
        bus.axi_rvalid = 0;
        tick();

`ifdef AXIL_ADAPTOR_ERRLOG_EN
        run_vec('{1'b0, 4'hF, 32'h300, 32'h0, 32'h3, 0, 2'b10, 32'h0, 1, 1, 1});
        chk("errlog_set", {err_sticky, err_addr}, {1'b1, 32'h300});
        run_vec('{1'b1, 4'h0, 32'h400, 32'h0, 32'h4, 0, 2'b10, 32'h0, 1, 0, 1});
        chk("errlog_keep_first", {err_sticky, err_addr}, {1'b1, 32'h300});
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("errlog_clear", {err_sticky, err_addr}, 0);
`endif

        // Reset in the middle of an issue discards everything.
        bus.axi_arready = 0;
        drive_req(1'b1, 4'h0, 32'h500, 32'h0, 32'h99);
        tick();
        bus.intf_req_val = 0;
        #1 chk("midrst_pre", bus.axi_arvalid, 1);
        rst_n = 0;
        bus.axi_rvalid = 1;
        #1 chk("midrst_clear", {bus.axi_arvalid, bus.intf_rsp_val}, 0);
        bus.axi_rvalid = 0;
        #1 rst_n = 1;
        tick();

        // Randomized run against the transaction model.
        do_reset();
        m_sticky = 0; m_addr = '0; slv_w_cnt = 0;
        begin
            logic f_req, f_ar, f_aw, f_w, f_r, f_b, f_pop, f_clr;
            logic p_aw, p_w, p_ar;
            logic [AW-1:0] p_awaddr, p_araddr;
            logic [DW+SW-1:0] p_wd;
            rsp_t e;
            int k;
            p_aw = 0; p_w = 0; p_ar = 0; p_awaddr = '0; p_araddr = '0; p_wd = '0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                @(negedge clk);
                if (cyc >= 3000 && exp_rsp_q.size() == 0 && !bus.intf_req_val) break;
                if (p_aw) chk("rnd_aw_hold", {bus.axi_awvalid, bus.axi_awaddr}, {1'b1, p_awaddr});
                if (p_w)  chk("rnd_w_hold", {bus.axi_wvalid, bus.axi_wdata, bus.axi_wstrb},
                              {1'b1, p_wd});
                if (p_ar) chk("rnd_ar_hold", {bus.axi_arvalid, bus.axi_araddr}, {1'b1, p_araddr});
`ifdef AXIL_ADAPTOR_ERRLOG_EN
                chk("rnd_errlog", {err_sticky, err_addr}, {m_sticky, m_addr});
                f_clr = err_clr;
`else
                f_clr = 0;
`endif
                f_req = bus.intf_req_val & bus.intf_req_ready;
                f_ar  = bus.axi_arvalid & bus.axi_arready;
                f_aw  = bus.axi_awvalid & bus.axi_awready;
                f_w   = bus.axi_wvalid & bus.axi_wready;
                f_r   = bus.axi_rvalid & bus.axi_rready;
                f_b   = bus.axi_bvalid & bus.axi_bready;
                f_pop = bus.intf_rsp_val & bus.intf_rsp_ready;
                p_aw = bus.axi_awvalid & ~f_aw; p_awaddr = bus.axi_awaddr;
                p_w  = bus.axi_wvalid & ~f_w;   p_wd = {bus.axi_wdata, bus.axi_wstrb};
                p_ar = bus.axi_arvalid & ~f_ar; p_araddr = bus.axi_araddr;
                if (f_pop) begin
                    if (exp_rsp_q.size() == 0) begin
                        chk("rnd_spurious_rsp", 1, 0);
                    end else begin
                        e = exp_rsp_q.pop_front();
                        chk("rnd_rsp", {bus.intf_rsp_tag, bus.intf_rsp_error}, {e.tag, e.err});
                        if (!e.wr) chk("rnd_rdata", bus.intf_rdata, e.rdata);
                        if (e.err && !m_sticky) begin
                            m_sticky = 1; m_addr = e.addr;
                        end
                    end
                end
                if (f_clr) begin
                    m_sticky = 0; m_addr = '0;
                end
                if (f_aw) begin
                    if (exp_aw_q.size() == 0) chk("rnd_spurious_aw", 1, 0);
                    else chk("rnd_awaddr", bus.axi_awaddr, exp_aw_q.pop_front());
                    slv_aw_q.push_back(bus.axi_awaddr);
                end
                if (f_w) begin
                    if (exp_w_q.size() == 0) chk("rnd_spurious_w", 1, 0);
                    else chk("rnd_wdata", {bus.axi_wdata, bus.axi_wstrb}, exp_w_q.pop_front());
                    slv_w_cnt++;
                end
                if (f_ar) begin
                    if (exp_ar_q.size() == 0) chk("rnd_spurious_ar", 1, 0);
                    else chk("rnd_araddr", bus.axi_araddr, exp_ar_q.pop_front());
                    slv_rd_q.push_back(bus.axi_araddr);
                end
                if (f_r) void'(slv_rd_q.pop_front());
                if (f_b) void'(slv_b_q.pop_front());
                while (slv_aw_q.size() > 0 && slv_w_cnt > 0) begin
                    slv_b_q.push_back(slv_aw_q.pop_front());
                    slv_w_cnt--;
                end
                if (f_req) begin
                    if (|bus.intf_wen) begin
                        exp_aw_q.push_back(bus.intf_addr);
                        exp_w_q.push_back({bus.intf_wdata, bus.intf_wen});
                        exp_rsp_q.push_back('{1'b1, bus.intf_req_tag, '0, bus.intf_addr[4],
                                              bus.intf_addr});
                    end else if (bus.intf_ren) begin
                        exp_ar_q.push_back(bus.intf_addr);
                        exp_rsp_q.push_back('{1'b0, bus.intf_req_tag, mem_rd(bus.intf_addr),
                                              bus.intf_addr[4], bus.intf_addr});
                    end
                end

                @(posedge clk);
                #1;
                if (!bus.intf_req_val || f_req) begin
                    k = int'($urandom_range(0, 9));
                    bus.intf_req_val  = (cyc < 3000) && ($urandom_range(0, 2) != 0);
                    bus.intf_ren      = (k >= 1 && k <= 4) || k == 9;
                    bus.intf_wen      = (k >= 5) ? SW'($urandom_range(1, 15)) : '0;
                    bus.intf_addr     = AW'({$urandom_range(0, 63), 2'b00});
                    bus.intf_wdata    = $urandom;
                    bus.intf_req_tag  = $urandom;
                end
                bus.axi_arready    = ($urandom_range(0, 1) != 0);
                bus.axi_awready    = ($urandom_range(0, 1) != 0);
                bus.axi_wready     = ($urandom_range(0, 1) != 0);
                bus.intf_rsp_ready = ($urandom_range(0, 3) != 0);
                if (!(bus.axi_rvalid && !f_r)) begin
                    if (slv_rd_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                        bus.axi_rvalid = 1;
                        bus.axi_rdata  = mem_rd(slv_rd_q[0]);
                        bus.axi_rresp  = {slv_rd_q[0][4], 1'($urandom_range(0, 1))};
                    end else begin
                        bus.axi_rvalid = 0;
                    end
                end
                if (!(bus.axi_bvalid && !f_b)) begin
                    if (slv_b_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                        bus.axi_bvalid = 1;
                        bus.axi_bresp  = {slv_b_q[0][4], 1'($urandom_range(0, 1))};
                    end else begin
                        bus.axi_bvalid = 0;
                    end
                end
`ifdef AXIL_ADAPTOR_ERRLOG_EN
                err_clr = ($urandom_range(0, 40) == 0);
`endif
            end
            chk("rnd_drain", 32'(exp_rsp_q.size()), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
